// File: rtl/pcie_dllp_pkg.sv
// Shared definitions for the PCIe DLLP receive checker and its CRC helper:
// CRC constants, receive FSM states and DLLP type codes.
package pcie_dllp_pkg;

    localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
    localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2
    } dllp_rx_state_e;

    localparam logic [7:0] DLLP_TYPE_ACK       = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK       = 8'h10;
    localparam logic [7:0] DLLP_TYPE_UPDFC_P   = 8'h80;
    localparam logic [7:0] DLLP_TYPE_UPDFC_NP  = 8'h90;
    localparam logic [7:0] DLLP_TYPE_UPDFC_CPL = 8'hA0;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pcie_dllp_crc16_calc.sv
// Combinational DLLP CRC-16 over the 4 content bytes; output is the expected
// CRC in wire order (byte 4 in [7:0], byte 5 in [15:8]). Shared with the TX side.
module pcie_dllp_crc16_calc
    import pcie_dllp_pkg::*;
(
    input  logic [31:0] content,
    output logic [15:0] crc_wire
);

    logic [15:0] rem;
    logic [15:0] crc_c;

    // content[i] walks byte 0 first, each byte LSB first, which is wire order
    always_comb begin
        rem = DLLP_CRC_SEED;
        for (int i = 0; i < 32; i++) begin
            if (rem[15] ^ content[i]) begin
                rem = {rem[14:0], 1'b0} ^ DLLP_CRC_POLY;
            end else begin
                rem = {rem[14:0], 1'b0};
            end
        end
    end

    assign crc_c    = ~rem;
    assign crc_wire = {bit_rev8(crc_c[7:0]), bit_rev8(crc_c[15:8])};

endmodule

// File: rtl/pcie_dllp_rx_check.sv
// Receive DLLP checker: assembles three 16-bit beats, verifies the CRC and
// forwards good DLLPs; counts good and bad DLLPs with saturating counters.
module pcie_dllp_rx_check
    import pcie_dllp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic [15:0]      in_data,
    input  logic             clr_cnt,
    output logic             dllp_valid,
    output logic [31:0]      dllp_data,
    output logic [7:0]       dllp_type,
    output logic             crc_err,
    output logic             frame_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                  input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    dllp_rx_state_e state, state_nxt;
    logic           cap_b0, cap_b1, cap_crc, trunc, ferr_nxt;
    logic [15:0]    byte01_p0, byte23_p0;
    logic [31:0]    content_p0;
    logic [15:0]    crc_exp_p0;
    logic           vld_p1, crc_ok_p1;
    logic [31:0]    content_p1;
    logic           good_inc;
    logic [1:0]     bad_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_b0    = 1'b0;
        cap_b1    = 1'b0;
        cap_crc   = 1'b0;
        trunc     = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_sop) begin
                    cap_b0    = 1'b1;
                    state_nxt = ST_B1;
                end else if (in_valid) begin
                    ferr_nxt = 1'b1;
                end
            end
            ST_B1, ST_B2: begin
                if (in_valid && in_sop) begin
                    // new start restarts assembly; the partial DLLP is counted bad
                    trunc     = 1'b1;
                    ferr_nxt  = 1'b1;
                    cap_b0    = 1'b1;
                    state_nxt = ST_B1;
                end else if (in_valid && (state == ST_B1)) begin
                    cap_b1    = 1'b1;
                    state_nxt = ST_B2;
                end else if (in_valid) begin
                    cap_crc   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: content capture
    always_ff @(posedge clk) begin
        if (cap_b0) byte01_p0 <= in_data;
        if (cap_b1) byte23_p0 <= in_data;
    end

    assign content_p0 = {byte23_p0, byte01_p0};

    pcie_dllp_crc16_calc u_crc (
        .content  (content_p0),
        .crc_wire (crc_exp_p0)
    );

    // Stage p1: CRC compare registered with the CRC beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            crc_ok_p1 <= 1'b0;
        end else begin
            vld_p1    <= cap_crc;
            crc_ok_p1 <= (crc_exp_p0 == in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (cap_crc) content_p1 <= content_p0;
    end

    assign good_inc = vld_p1 & crc_ok_p1;
    assign bad_inc  = {1'b0, trunc} + {1'b0, vld_p1 & ~crc_ok_p1};

    // Stage p2: output pulses, forwarded DLLP and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dllp_valid <= 1'b0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
            dllp_data  <= '0;
            dllp_type  <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            dllp_valid <= good_inc;
            crc_err    <= vld_p1 & ~crc_ok_p1;
            frame_err  <= ferr_nxt;
            if (good_inc) begin
                dllp_data <= content_p1;
                dllp_type <= content_p1[7:0];
            end
            good_cnt <= clr_cnt ? '0 : sat_add(good_cnt, {1'b0, good_inc});
            bad_cnt  <= clr_cnt ? '0 : sat_add(bad_cnt, bad_inc);
        end
    end

endmodule

// File: tb/tb_pcie_dllp_rx_check.sv
// Directed bench for pcie_dllp_rx_check: table of single DLLPs plus hand-written
// sequences for truncation, back-to-back traffic, counter clear and mid-DLLP reset.
module tb_pcie_dllp_rx_check;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_sop, clr_cnt;
    logic [15:0] in_data;

    logic        dllp_valid, crc_err, frame_err;
    logic [31:0] dllp_data;
    logic [7:0]  dllp_type;
    logic [15:0] good_cnt, bad_cnt;

    logic        s_dllp_valid, s_crc_err, s_frame_err;
    logic [31:0] s_dllp_data;
    logic [7:0]  s_dllp_type;
    logic [1:0]  s_good_cnt, s_bad_cnt;

    always #5 clk = ~clk;

    pcie_dllp_rx_check #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
        .in_data(in_data), .clr_cnt(clr_cnt), .dllp_valid(dllp_valid),
        .dllp_data(dllp_data), .dllp_type(dllp_type), .crc_err(crc_err),
        .frame_err(frame_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    // narrow-counter copy on the same stimulus exercises saturation quickly
    pcie_dllp_rx_check #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
        .in_data(in_data), .clr_cnt(clr_cnt), .dllp_valid(s_dllp_valid),
        .dllp_data(s_dllp_data), .dllp_type(s_dllp_type), .crc_err(s_crc_err),
        .frame_err(s_frame_err), .good_cnt(s_good_cnt), .bad_cnt(s_bad_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0, n_crc = 0, n_ferr = 0;
    int s_n_valid = 0, s_n_crc = 0, s_n_ferr = 0;
    int tot_valid = 0, tot_crc = 0, tot_ferr = 0;
    int v0, c0, f0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;

    typedef struct {
        logic [31:0] content;
        logic [15:0] crc_x;
        int          gap;
        logic        exp_good;
        logic [15:0] exp_gcnt;
        logic [15:0] exp_bcnt;
    } vec_t;
    vec_t vecs[7];

    always @(posedge clk) begin
        #1;
        if (dllp_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(dllp_data);
        end
        if (crc_err === 1'b1)      n_crc++;
        if (frame_err === 1'b1)    n_ferr++;
        if (s_dllp_valid === 1'b1) s_n_valid++;
        if (s_crc_err === 1'b1)    s_n_crc++;
        if (s_frame_err === 1'b1)  s_n_ferr++;
    end

    // reflected-register form of the DLLP CRC; result is already in wire order
    function automatic logic [15:0] model_crc(input logic [31:0] c);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (r[0] ^ c[i]) r = (r >> 1) ^ 16'hD008;
            else             r = r >> 1;
        end
        return ~r;
    endfunction

    function automatic logic [1:0] sat2(input logic [15:0] x);
        return (x > 16'd3) ? 2'd3 : x[1:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic snap();
        v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    endtask

    task automatic expect_pulses(input string nm, input int ev, input int ec, input int ef);
        check({nm, "_valid_pulses"}, n_valid - v0, ev);
        check({nm, "_crc_err_pulses"}, n_crc - c0, ec);
        check({nm, "_frame_err_pulses"}, n_ferr - f0, ef);
        tot_valid += ev; tot_crc += ec; tot_ferr += ef;
    endtask

    task automatic check_cnts(input string nm, input logic [15:0] g, input logic [15:0] b);
        check({nm, "_good_cnt"}, good_cnt, g);
        check({nm, "_bad_cnt"}, bad_cnt, b);
        check({nm, "_sat_good_cnt"}, s_good_cnt, sat2(g));
        check({nm, "_sat_bad_cnt"}, s_bad_cnt, sat2(b));
    endtask

    task automatic beat(input logic sop, input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_sop = sop; in_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; in_sop = 1'b0; in_data = 16'h0;
        end
    endtask

    task automatic send_dllp(input logic [31:0] c, input logic [15:0] x, input int gap);
        beat(1'b1, c[15:0]);
        idle(gap);
        beat(1'b0, c[31:16]);
        idle(gap);
        beat(1'b0, model_crc(c) ^ x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 16'h0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_data = 32'h0;
    endtask

    initial begin
        logic [31:0] c;
        reset = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 16'h0; clr_cnt = 1'b0;
        exp_data = 32'h0;

        vecs[0] = '{32'h0000_0000, 16'h0000, 0, 1'b1, 16'd1, 16'd0};
        vecs[1] = '{32'h0000_0000, 16'h0100, 0, 1'b0, 16'd1, 16'd1};
        vecs[2] = '{32'h1234_0010, 16'h0000, 1, 1'b1, 16'd2, 16'd1};
        vecs[3] = '{32'hA5C3_0180, 16'h0000, 2, 1'b1, 16'd3, 16'd1};
        vecs[4] = '{32'hDEAD_BE90, 16'h0001, 0, 1'b0, 16'd3, 16'd2};
        vecs[5] = '{32'hFFFF_FFA0, 16'h0000, 0, 1'b1, 16'd4, 16'd2};
        vecs[6] = '{32'h0000_0000, 16'h8000, 1, 1'b0, 16'd4, 16'd3};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_dllp_valid", dllp_valid, 0);
        check("rst_crc_err", crc_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_dllp_data", dllp_data, 0);
        check("rst_dllp_type", dllp_type, 0);
        check_cnts("rst", 16'd0, 16'd0);
        reset = 1'b1;

        // latency and pulse width of a good all-zero DLLP
        snap();
        send_dllp(32'h0, 16'h0, 0);
        @(posedge clk); #1;
        check("lat_edge_n_valid", dllp_valid, 0);
        in_valid = 1'b0; in_sop = 1'b0; in_data = 16'h0;
        @(posedge clk); #1;
        check("lat_edge_n1_valid", dllp_valid, 1);
        check("lat_data", dllp_data, 32'h0);
        check("lat_type", dllp_type, 8'h00);
        check_cnts("lat", 16'd1, 16'd0);
        @(posedge clk); #1;
        check("lat_pulse_end", dllp_valid, 0);
        idle(2);
        expect_pulses("lat", 1, 0, 0);

        // table of single DLLPs
        do_reset();
        foreach (vecs[i]) begin
            snap();
            send_dllp(vecs[i].content, vecs[i].crc_x, vecs[i].gap);
            idle(4);
            expect_pulses($sformatf("vec%0d", i), vecs[i].exp_good ? 1 : 0,
                          vecs[i].exp_good ? 0 : 1, 0);
            if (vecs[i].exp_good) exp_data = vecs[i].content;
            check($sformatf("vec%0d_data", i), dllp_data, exp_data);
            check($sformatf("vec%0d_type", i), dllp_type, exp_data[7:0]);
            check_cnts($sformatf("vec%0d", i), vecs[i].exp_gcnt, vecs[i].exp_bcnt);
        end

        // truncation in B1, in B2, and a stray beat in IDLE
        do_reset();
        snap();
        beat(1'b1, 16'hBEEF);
        send_dllp(32'h00C8_0000, 16'h0, 0);
        idle(4);
        expect_pulses("trunc_b1", 1, 0, 1);
        check("trunc_b1_data", dllp_data, 32'h00C8_0000);
        check_cnts("trunc_b1", 16'd1, 16'd1);
        snap();
        beat(1'b1, 16'h0123);
        beat(1'b0, 16'h4567);
        send_dllp(32'h0F0F_0E10, 16'h0, 0);
        idle(4);
        expect_pulses("trunc_b2", 1, 0, 1);
        check("trunc_b2_data", dllp_data, 32'h0F0F_0E10);
        check("trunc_b2_type", dllp_type, 8'h10);
        check_cnts("trunc_b2", 16'd2, 16'd2);
        exp_data = 32'h0F0F_0E10;
        snap();
        beat(1'b0, 16'h1111);
        @(posedge clk); #1;
        check("stray_ferr_on", frame_err, 1);
        in_valid = 1'b0; in_data = 16'h0;
        @(posedge clk); #1;
        check("stray_ferr_off", frame_err, 0);
        idle(2);
        expect_pulses("stray", 0, 0, 1);
        check_cnts("stray", 16'd2, 16'd2);

        // 10 back-to-back DLLPs, then 10 with random idle gaps
        do_reset();
        got_q.delete();
        exp_q.delete();
        snap();
        for (int i = 0; i < 20; i++) begin
            c = $urandom;
            exp_q.push_back(c);
            send_dllp(c, 16'h0, (i < 10) ? 0 : int'($urandom_range(0, 3)));
        end
        idle(4);
        expect_pulses("b2b", 20, 0, 0);
        check("b2b_count", got_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("b2b_order%0d", i), (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
        end
        check_cnts("b2b", 16'd20, 16'd0);
        exp_data = exp_q[19];

        // clear coincident with a good result
        snap();
        send_dllp(32'h5555_AA00, 16'h0, 0);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_data = 16'h0; clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        idle(3);
        expect_pulses("clr", 1, 0, 0);
        check("clr_data", dllp_data, 32'h5555_AA00);
        check_cnts("clr", 16'd0, 16'd0);
        snap();
        send_dllp(32'h0102_0300, 16'h0, 0);
        idle(4);
        expect_pulses("after_clr", 1, 0, 0);
        check_cnts("after_clr", 16'd1, 16'd0);

        // reset after beat 1, and reset with a result in flight
        snap();
        beat(1'b1, 16'h7710);
        beat(1'b0, 16'h3322);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(4);
        expect_pulses("rst_mid", 0, 0, 0);
        check_cnts("rst_mid", 16'd0, 16'd0);
        snap();
        send_dllp(32'h3322_7710, 16'h0, 0);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        expect_pulses("rst_flight", 0, 0, 0);
        check("rst_flight_data", dllp_data, 32'h0);
        check_cnts("rst_flight", 16'd0, 16'd0);
        snap();
        send_dllp(32'h3322_7710, 16'h0, 0);
        idle(4);
        expect_pulses("post_rst", 1, 0, 0);
        check("post_rst_data", dllp_data, 32'h3322_7710);
        check("post_rst_type", dllp_type, 8'h10);
        check_cnts("post_rst", 16'd1, 16'd0);
        exp_data = 32'h3322_7710;

        // narrow-counter instance saw the same traffic
        check("sat_inst_valid_total", s_n_valid, tot_valid);
        check("sat_inst_crc_total", s_n_crc, tot_crc);
        check("sat_inst_ferr_total", s_n_ferr, tot_ferr);
        check("sat_inst_data", s_dllp_data, exp_data);
        check("sat_inst_type", s_dllp_type, exp_data[7:0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_dllp_rx_check.md
# pcie_dllp_rx_check

Receive-side Data Link Layer Packet checker for the PCIe data link layer. It takes 6-byte DLLPs from the receive framing logic as three 16-bit beats and recomputes the 16-bit DLLP CRC over the 4 content bytes. It compares that CRC against the received CRC bytes and forwards only good DLLPs to the Ack/Nak and flow-control logic. It is the counterpart of the transmit-side DLLP CRC generator and uses the same polynomial, seed and bit mapping.

## Interface
- `CNT_W`, default 16: width of the saturating good/bad DLLP counters.
- `clk`  in  1  receive-side link clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat valid from framing logic.
- `in_sop`  in  1  marks the first beat of a DLLP; qualified by `in_valid`.
- `in_data`  in  16  beat data; `[7:0]` is the earlier byte on the wire.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `dllp_valid`  out  1  one-cycle pulse: good DLLP on `dllp_data`.
- `dllp_data`  out  32  content bytes 0..3; byte 0 is in `[7:0]`.
- `dllp_type`  out  8  byte 0 of the DLLP (type field); valid with `dllp_valid`.
- `crc_err`  out  1  one-cycle pulse: a complete DLLP failed the CRC check.
- `frame_err`  out  1  one-cycle pulse on a framing violation.
- `good_cnt`  out  CNT_W  saturating count of good DLLPs.
- `bad_cnt`  out  CNT_W  saturating count of CRC-failed plus truncated DLLPs.

## Operation
- Frame layout:
  - beat 0 carries bytes 0-1; beat 1 carries bytes 2-3; beat 2 carries CRC bytes 4-5.
  - Beats are accepted only when `in_valid`=1. Idle gaps between beats are allowed and the FSM holds its state.
- FSM states: IDLE, B1, B2.
  - IDLE: `in_valid & in_sop` captures bytes 0-1 and moves to B1. `in_valid & !in_sop` pulses `frame_err`; the beat is dropped and the FSM stays in IDLE.
  - B1: `in_valid & !in_sop` captures bytes 2-3 and moves to B2.
  - B2: `in_valid & !in_sop` captures the CRC, launches the compare and moves to IDLE.
  - `in_sop` in B1 or B2 truncates the partial DLLP: pulse `frame_err`, increment `bad_cnt`, treat the new beat as beat 0 and go to B1.
- CRC definition:
  - Polynomial 100Bh, seed FFFFh.
  - Bytes 0..3 are fed in wire order, each byte LSB first.
  - Remainder R is complemented: C = ~R.
  - Expected byte 4 = bit-reverse(C[15:8]); expected byte 5 = bit-reverse(C[7:0]).
- Compare result:
  - Match: pulse `dllp_valid` with `dllp_data` and `dllp_type`, and increment `good_cnt`.
  - Mismatch: pulse `crc_err` and increment `bad_cnt`. `dllp_valid` stays 0, and `dllp_data` holds its previous value.
- Counters:
  - Saturate at all-ones and do not wrap.
  - `clr_cnt` wins over a same-cycle increment; the counter reads 0 on the next cycle.
  - A truncation and a CRC result in the same cycle increment `bad_cnt` by 2, saturating.
- No backpressure: downstream must accept every `dllp_valid` pulse.

## Timing
- Reset values:
  - FSM is in IDLE.
  - `dllp_valid`, `crc_err` and `frame_err` are 0.
  - `dllp_data`, `dllp_type`, `good_cnt` and `bad_cnt` are 0.
- Latency: the CRC beat is accepted at edge N; `dllp_valid` or `crc_err` is high for exactly the cycle after edge N+1.
  - Stage 1: CRC compute and compare, registered.
  - Stage 2: output registers.
- `frame_err` is registered and asserts for the cycle after the offending beat's edge.
- Counters update on the same edge that raises the corresponding pulse.
- Throughput: back-to-back DLLPs with no idle beats are supported. The pipeline accepts a new beat 0 in the same cycle the previous compare is in flight.
- Reset asserted mid-DLLP discards the partial capture and any in-flight result; no pulse is emitted after reset deasserts.

## Structure
- Package `pcie_dllp_pkg` holds:
  - localparams `DLLP_CRC_POLY`=16'h100B and `DLLP_CRC_SEED`=16'hFFFF;
  - the FSM state enum;
  - DLLP type constants: Ack 8'h00, Nak 8'h10, and the UpdateFC-P/NP/Cpl base codes.
- Sub-module `pcie_dllp_crc16_calc`: purely combinational, 32-bit content in, 16-bit expected wire-order CRC out. It implements the polynomial, complement and byte bit-reversal above. The transmit side instantiates the same sub-module.

## Test plan
- Reset, then a good DLLP (type 00h, bytes 00 00 00 00 plus the model-computed CRC) in 3 consecutive beats -> one `dllp_valid` 2 cycles after beat 2, `dllp_data`=0000_0000h, `good_cnt`=1, `bad_cnt`=0.
- Same DLLP with byte 5 bit 0 flipped -> `crc_err` pulse only, no `dllp_valid`, `bad_cnt`=1.
- Beat 0, then `in_sop` again in B1, followed by a full good DLLP -> `frame_err` once, `bad_cnt`=1, then `dllp_valid` for the second DLLP, `good_cnt`=1.
- 10 good DLLPs back-to-back with no gaps, then 10 more with random idle gaps -> 20 `dllp_valid` pulses in order, `good_cnt`=20.
- Force `good_cnt` to FFFEh via `CNT_W`=16 plus 2 good DLLPs -> holds at FFFFh. `clr_cnt` coincident with a good DLLP result -> `good_cnt`=0.
- `reset` asserted after beat 1 of a DLLP, then released -> no output pulses, counters 0, and the next good DLLP is checked normally.
